gf283_reduce: RTL and testbench

GF283_REDUCE -- requirements
Module: gf283_reduce

---
 rtl/gf283_reduce_if.sv | 27 ++
 rtl/gf283_reduce.sv | 116 +++++++++++
 tb/tb_gf283_reduce.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/gf283_reduce_if.sv
// rtl/gf283_reduce_if.sv - product-in / result-out handshake bundle for gf283_reduce
interface gf283_reduce_if;
   logic         in_valid;
   logic         in_ready;
   logic [565:0] c_in;
   logic         out_valid;
   logic         out_ready;
   logic [282:0] r;

   modport master (
      output in_valid,
      output c_in,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  r
   );

   modport slave (
      input  in_valid,
      input  c_in,
      input  out_ready,
      output in_ready,
      output out_valid,
      output r
   );
endinterface

// File: rtl/gf283_reduce.sv
// rtl/gf283_reduce.sv - digit-serial reduction of a 566-bit carry-less product modulo x^283+x^12+x^7+x^5+1
module gf283_reduce #(
   parameter int DIGIT = 32
) (
   input  logic          clk,
   input  logic          rst,
   gf283_reduce_if.slave bus
);

   localparam int M     = 283;
   localparam int ACC_W = 566;
   localparam int N     = (M + DIGIT - 1) / DIGIT;
   localparam int KW    = $clog2(N + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [KW-1:0]    k_q, k_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [M-1:0]     r_q, r_d;

   logic [9:0]       lo_w;
   logic [9:0]       q_w;
   logic [DIGIT-1:0] h_w;
   logic [ACC_W-1:0] h_ext_w;
   logic [ACC_W-1:0] keep_mask_w;
   logic [ACC_W-1:0] fold_w;
   logic             in_fire_w;
   logic             out_fire_w;
   logic             last_w;

   // Low bit index of window k; the final window is clipped at x^283.
   function automatic logic [9:0] win_lo(input logic [KW-1:0] k);
      int t;
      t = ACC_W - (int'(k) + 1) * DIGIT;
      if (t < M) begin
         t = M;
      end
      return 10'(t);
   endfunction

   assign in_fire_w  = bus.in_valid && (state_q == IDLE);
   assign out_fire_w = bus.out_ready && (state_q == HOLD);
   assign last_w     = (k_q == KW'(N));

   // Everything above the current window is already zero, so a plain
   // right shift isolates the window without needing its upper bound.
   assign lo_w        = win_lo(k_q);
   assign q_w         = lo_w - 10'(M);
   assign h_w         = DIGIT'(acc_q >> lo_w);
   assign h_ext_w     = {{(ACC_W - DIGIT){1'b0}}, h_w};
   assign keep_mask_w = ~({ACC_W{1'b1}} << lo_w);
   assign fold_w      = (h_ext_w << q_w)
                      ^ (h_ext_w << (q_w + 10'd5))
                      ^ (h_ext_w << (q_w + 10'd7))
                      ^ (h_ext_w << (q_w + 10'd12));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (in_fire_w)  state_d = RUN;
         RUN:     if (last_w)     state_d = HOLD;
         HOLD:    if (out_fire_w) state_d = IDLE;
         default:                 state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.in_ready  = (state_q == IDLE);
      bus.out_valid = (state_q == HOLD);
      bus.r         = r_q;
   end

   // The cycle after the last fold only publishes acc[282:0] into r.
   always_comb begin
      k_d   = k_q;
      acc_d = acc_q;
      r_d   = r_q;
      if (in_fire_w) begin
         acc_d = bus.c_in;
         k_d   = '0;
      end else if (state_q == RUN) begin
         if (last_w) begin
            r_d = acc_q[M-1:0];
         end else begin
            acc_d = (acc_q & keep_mask_w) ^ fold_w;
            k_d   = k_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         k_q   <= '0;
         acc_q <= '0;
         r_q   <= '0;
      end else begin
         k_q   <= k_d;
         acc_q <= acc_d;
         r_q   <= r_d;
      end
   end

endmodule

// File: tb/tb_gf283_reduce.sv
// tb/tb_gf283_reduce.sv - self-checking bench for gf283_reduce at DIGIT 8, 32 and 64
module tb_gf283_reduce;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst;
   logic         iv_t;
   logic         or_t;
   logic [1:0]   sel_t;
   logic [565:0] cin_t;

   logic         ir [3];
   logic         ov [3];
   logic [282:0] rr [3];

   int n_tests = 0;
   int n_fail  = 0;

   gf283_reduce_if ifc [3] ();

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int D = (g == 0) ? 8 : (g == 1) ? 32 : 64;
      assign ifc[g].in_valid  = iv_t && (sel_t == 2'(g));
      assign ifc[g].c_in      = cin_t;
      assign ifc[g].out_ready = or_t && (sel_t == 2'(g));
      assign ir[g] = ifc[g].in_ready;
      assign ov[g] = ifc[g].out_valid;
      assign rr[g] = ifc[g].r;
      gf283_reduce #(.DIGIT(D)) u_dut (
         .clk (clk),
         .rst (rst),
         .bus (ifc[g])
      );
   end

   function automatic int dig(input int sel);
      return (sel == 0) ? 8 : (sel == 1) ? 32 : 64;
   endfunction

   function automatic int n_of(input int sel);
      return (283 + dig(sel) - 1) / dig(sel);
   endfunction

   // Schoolbook long division by f(x), one set bit at a time from the top.
   function automatic logic [282:0] ref_mod(input logic [565:0] c);
      logic [565:0] a;
      logic [565:0] f;
      a = c;
      f = (566'd1 << 283) | (566'd1 << 12) | (566'd1 << 7) | (566'd1 << 5) | 566'd1;
      for (int i = 565; i >= 283; i--) begin
         if (a[i]) a = a ^ (f << (i - 283));
      end
      return a[282:0];
   endfunction

   function automatic logic [565:0] rand_c(input int mode);
      logic [575:0] t;
      for (int w = 0; w < 18; w++) t[w*32 +: 32] = $urandom;
      case (mode)
         1: t[565] = 1'b1;
         2: begin
            t = '0;
            for (int j = 0; j < 1 + int'($urandom_range(0, 2)); j++)
               t[$urandom_range(0, 565)] = 1'b1;
         end
         3: t[282:0] = '0;
         default: ;
      endcase
      return t[565:0];
   endfunction

   task automatic chk(input string name, input logic [282:0] got, input logic [282:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic run_op(input int sel, input logic [565:0] c, input bit rnd_ready,
                         input string tag, output logic [282:0] res);
      int  lat;
      int  guard;
      bit  took;
      guard = 0;
      while (!ir[sel] && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      chk({tag, " in_ready"}, 283'(ir[sel]), 283'(1));
      sel_t = 2'(sel);
      cin_t = c;
      iv_t  = 1'b1;
      @(negedge clk);
      iv_t  = 1'b0;
      cin_t = ~c;
      lat = 0;
      while (!ov[sel] && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      chk({tag, " latency"}, 283'(lat), 283'(n_of(sel) + 1));
      res   = rr[sel];
      took  = 1'b0;
      guard = 0;
      while (!took) begin
         or_t = (rnd_ready && guard < 20) ? 1'($urandom_range(0, 1)) : 1'b1;
         took = or_t;
         @(negedge clk);
         guard++;
         if (!took) begin
            chk({tag, " hold r"}, rr[sel], res);
         end
      end
      or_t = 1'b0;
      chk({tag, " out_valid drop"}, 283'(ov[sel]), 283'(0));
      chk({tag, " in_ready back"}, 283'(ir[sel]), 283'(1));
   endtask

   typedef struct {
      logic [565:0] c;
      logic [282:0] r;
   } vec_t;

   vec_t         tbl [7];
   logic [565:0] c1;
   logic [282:0] r1;
   logic [282:0] res;
   logic [565:0] c;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst   = 1'b0;
      iv_t  = 1'b0;
      or_t  = 1'b0;
      sel_t = 2'd0;
      cin_t = '0;
      #12;
      for (int s = 0; s < 3; s++) begin
         chk($sformatf("reset in_ready d%0d", dig(s)), 283'(ir[s]), 283'(1));
         chk($sformatf("reset out_valid d%0d", dig(s)), 283'(ov[s]), 283'(0));
         chk($sformatf("reset r d%0d", dig(s)), rr[s], 283'(0));
      end
      @(negedge clk);
      rst = 1'b1;

      c1 = 566'd1;
      r1 = 283'd1;
      tbl[0].c = c1;                  tbl[0].r = r1;
      tbl[1].c = c1 << 283;           tbl[1].r = 283'h10A1;
      tbl[2].c = c1 << 564;
      tbl[2].r = (r1 << 281) | (r1 << 22) | (r1 << 12) | (r1 << 10) | (r1 << 8) | (r1 << 5) | (r1 << 3);
      tbl[3].c = '0;                  tbl[3].r = '0;
      tbl[4].c = c1 << 282;           tbl[4].r = r1 << 282;
      tbl[5].c = (c1 << 565) | c1;
      tbl[5].r = (r1 << 282) | (r1 << 23) | (r1 << 13) | (r1 << 11) | (r1 << 9) | (r1 << 6) | (r1 << 4) | r1;
      tbl[6].c = (c1 << 283) | (c1 << 12) | (c1 << 7) | (c1 << 5) | c1;
      tbl[6].r = '0;

      for (int i = 0; i < 7; i++) begin
         run_op(1, tbl[i].c, 1'b0, $sformatf("vec%0d", i), res);
         chk($sformatf("vec%0d r", i), res, tbl[i].r);
      end

      // Back-pressure with in_valid left high through RUN and HOLD.
      c = rand_c(0);
      sel_t = 2'd1;
      cin_t = c;
      iv_t  = 1'b1;
      @(negedge clk);
      cin_t = ~c;
      for (int w = 0; w < 200 && !ov[1]; w++) @(negedge clk);
      res = rr[1];
      chk("bp out_valid", 283'(ov[1]), 283'(1));
      chk("bp r", res, ref_mod(c));
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp hold out_valid", 283'(ov[1]), 283'(1));
         chk("bp hold r", rr[1], res);
         chk("bp hold in_ready", 283'(ir[1]), 283'(0));
      end
      iv_t = 1'b0;
      or_t = 1'b1;
      @(negedge clk);
      or_t = 1'b0;
      chk("bp taken out_valid", 283'(ov[1]), 283'(0));
      chk("bp taken in_ready", 283'(ir[1]), 283'(1));

      // Reset in the middle of RUN discards the operation.
      c = rand_c(0);
      cin_t = c;
      iv_t  = 1'b1;
      @(negedge clk);
      iv_t = 1'b0;
      repeat (4) @(negedge clk);
      #1 rst = 1'b0;
      #1;
      chk("midrst out_valid", 283'(ov[1]), 283'(0));
      chk("midrst in_ready", 283'(ir[1]), 283'(1));
      chk("midrst r", rr[1], 283'(0));
      @(negedge clk);
      rst = 1'b1;
      c = rand_c(0);
      run_op(1, c, 1'b1, "postrst", res);
      chk("postrst r", res, ref_mod(c));

      for (int s = 0; s < 3; s++) begin
         for (int i = 0; i < 150; i++) begin
            c = rand_c(i % 4);
            run_op(s, c, 1'b1, $sformatf("rnd d%0d #%0d", dig(s), i), res);
            chk($sformatf("rnd d%0d #%0d r", dig(s), i), res, ref_mod(c));
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
